pot_scan: RTL and testbench

POT_SCAN -- requirements
Module: pot_scan

---
 rtl/pot_scan.sv | 142 ++++++++++++++
 tb/tb_pot_scan.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pot_scan.sv
// rtl/pot_scan.sv - round-robin six-pot SPI A2D scanner
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-high reset
//   SS_n       A2D chip select, active-low
//   SCLK       SPI clock, idles high
//   MOSI       SPI command data, MSB first
//   MISO       SPI result data, MSB first
//   POT_LP..VOLUME  registered 12-bit pot values
//   scan_done  one-clk pulse after VOLUME is written
module pot_scan #(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic [11:0] POT_LP,
    output logic [11:0] POT_B1,
    output logic [11:0] POT_B2,
    output logic [11:0] POT_B3,
    output logic [11:0] POT_HP,
    output logic [11:0] VOLUME,
    output logic        scan_done
);

    localparam int PW = $clog2(SCLK_DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(SCLK_DIV - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(SCLK_DIV / 2);

    // GAP2 doubles as the store state: the pot write happens on entry.
    typedef enum logic [2:0] {IDLE, FRAME1, GAP1, FRAME2, GAP2} state_t;

    state_t        state;
    logic [PW-1:0] ph;         // position inside the current SCLK period / gap
    logic [4:0]    nbit;       // SCLK rising edges completed in this frame
    logic [2:0]    idx;
    logic [14:0]   cmd_sr;     // command bits still to send; bit 15 goes out at SS_n fall
    logic [11:0]   rx_sr;      // upper four result bits shift out the top and are ignored
    logic [11:0]   pot [6];
    logic          done_pend;

    logic [PW-1:0] ph_next;
    logic [15:0]   cmd;

    function automatic logic [2:0] chan_of(input logic [2:0] i);
        case (i)
            3'd0:    chan_of = 3'd1;
            3'd1:    chan_of = 3'd0;
            3'd2:    chan_of = 3'd4;
            3'd3:    chan_of = 3'd2;
            3'd4:    chan_of = 3'd3;
            default: chan_of = 3'd7;
        endcase
    endfunction

    assign ph_next = (ph == PH_LAST) ? '0 : ph + 1'b1;
    assign cmd     = {2'b00, chan_of(idx), 11'h000};

    assign POT_LP = pot[0];
    assign POT_B1 = pot[1];
    assign POT_B2 = pot[2];
    assign POT_B3 = pot[3];
    assign POT_HP = pot[4];
    assign VOLUME = pot[5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            SS_n      <= 1'b1;
            SCLK      <= 1'b1;
            MOSI      <= 1'b0;
            ph        <= '0;
            nbit      <= '0;
            idx       <= '0;
            cmd_sr    <= '0;
            rx_sr     <= '0;
            done_pend <= 1'b0;
            scan_done <= 1'b0;
            for (int i = 0; i < 6; i++) pot[i] <= '0;
        end else begin
            scan_done <= done_pend;
            done_pend <= 1'b0;
            case (state)
                IDLE, GAP1, GAP2: begin
                    // Gap lasts exactly SCLK_DIV clks; IDLE starts at once.
                    if (state == IDLE || ph == PH_LAST) begin
                        SS_n   <= 1'b0;
                        SCLK   <= 1'b1;
                        MOSI   <= cmd[15];
                        cmd_sr <= cmd[14:0];
                        rx_sr  <= '0;
                        ph     <= '0;
                        nbit   <= '0;
                        state  <= (state == GAP1) ? FRAME2 : FRAME1;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                FRAME1, FRAME2: begin
                    ph <= ph_next;
                    if (nbit != 5'd16) begin
                        if (ph_next == PH_HALF) begin
                            SCLK <= 1'b0;
                            // MOSI already holds bit 15 for the first falling edge.
                            if (nbit != 5'd0) begin
                                MOSI   <= cmd_sr[14];
                                cmd_sr <= {cmd_sr[13:0], 1'b0};
                            end
                        end else if (ph_next == '0) begin
                            SCLK  <= 1'b1;
                            rx_sr <= {rx_sr[10:0], MISO};
                            nbit  <= nbit + 1'b1;
                        end
                    end else if (ph_next == PH_HALF) begin
                        // Half a period after the 16th rising edge the frame ends.
                        SS_n <= 1'b1;
                        MOSI <= 1'b0;
                        ph   <= '0;
                        if (state == FRAME1) begin
                            state <= GAP1;
                        end else begin
                            pot[idx] <= rx_sr;
                            state    <= GAP2;
                            if (idx == 3'd5) begin
                                idx       <= '0;
                                done_pend <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pot_scan.sv
// tb/tb_pot_scan.sv - self-checking bench for pot_scan with SPI slave model
module tb_pot_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MISO = 1'b0;
    logic        SS_n, SCLK, MOSI, scan_done;
    logic [11:0] POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME;

    pot_scan #(.SCLK_DIV(32)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .POT_LP(POT_LP), .POT_B1(POT_B1), .POT_B2(POT_B2), .POT_B3(POT_B3),
        .POT_HP(POT_HP), .VOLUME(VOLUME), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] cmd;
        logic [15:0] resp;
        logic [11:0] pot;
    } conv_t;

    conv_t tbl [6];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] pot_of(input int i);
        case (i)
            0: pot_of = POT_LP;
            1: pot_of = POT_B1;
            2: pot_of = POT_B2;
            3: pot_of = POT_B3;
            4: pot_of = POT_HP;
            default: pot_of = VOLUME;
        endcase
    endfunction

    // SPI slave model and protocol monitor, sampled on the falling clk edge
    logic [15:0] cmd_log[$];
    int          done_cyc[$];
    int cyc = 0, fall_cnt = 0, vol_cyc = -1;
    int err_low = 0, err_gap = 0, err_rises = 0, err_run = 0, err_mosi = 0;
    int err_idle = 0, err_1234 = 0, err_done_w = 0;
    int low_len, gap_len, run_len, rises, bitk, done_w = 0;
    bit in_frame = 0, gap_ok = 0, par = 0;
    logic [15:0] rxw, txw;
    logic [2:0]  last_ch = 3'd0;
    logic prev_ss = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0, prev_done = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_frame = 0;
            gap_ok   = 0;
            par      = 0;
            MISO     = ~MISO;
        end else begin
            if (prev_ss && !SS_n) begin
                fall_cnt++;
                in_frame = 1;
                low_len  = 1;
                run_len  = 1;
                rises    = 0;
                bitk     = 0;
                rxw      = '0;
                if (gap_ok && gap_len != 32) err_gap++;
                txw = 16'h1234;
                if (par) begin
                    for (int i = 0; i < 6; i++)
                        if (tbl[i].ch == last_ch) txw = tbl[i].resp;
                end
                MISO = txw[15];
            end else if (!SS_n && in_frame) begin
                low_len++;
                if (SCLK != prev_sclk) begin
                    if (run_len != 16) err_run++;
                    run_len = 1;
                    if (SCLK) begin
                        if (MOSI != prev_mosi) err_mosi++;
                        rxw = {rxw[14:0], MOSI};
                        rises++;
                        bitk++;
                    end else if (bitk > 0 && bitk < 16) begin
                        MISO = txw[15 - bitk];
                    end
                end else begin
                    run_len++;
                end
            end else if (!prev_ss && SS_n && in_frame) begin
                if (run_len != 16) err_run++;
                if (low_len != 528) err_low++;
                if (rises != 16) err_rises++;
                if (SCLK !== 1'b1 || MOSI !== 1'b0) err_idle++;
                cmd_log.push_back(rxw);
                if (!par) last_ch = rxw[13:11];
                par      = ~par;
                in_frame = 0;
                gap_ok   = 1;
                gap_len  = 1;
                MISO     = 1'b0;
            end else if (SS_n) begin
                gap_len++;
                if (SCLK !== 1'b1 || MOSI !== 1'b0) err_idle++;
            end
            for (int i = 0; i < 6; i++)
                if (pot_of(i) == 12'h234) err_1234++;
            if (vol_cyc < 0 && VOLUME != 12'h000) vol_cyc = cyc;
            if (scan_done) begin
                if (!prev_done) done_cyc.push_back(cyc);
                done_w++;
            end else if (prev_done) begin
                if (done_w != 1) err_done_w++;
                done_w = 0;
            end
        end
        prev_ss   = SS_n;
        prev_sclk = SCLK;
        prev_mosi = MOSI;
        prev_done = scan_done;
    end

    initial begin
        logic [11:0] pre_lp;
        bit          ok;
        int          n;

        tbl[0] = '{3'd1, 16'h0800, 16'hFABC, 12'hABC};
        tbl[1] = '{3'd0, 16'h0000, 16'hE123, 12'h123};
        tbl[2] = '{3'd4, 16'h2000, 16'h0456, 12'h456};
        tbl[3] = '{3'd2, 16'h1000, 16'h5789, 12'h789};
        tbl[4] = '{3'd3, 16'h1800, 16'h35A5, 12'h5A5};
        tbl[5] = '{3'd7, 16'h3800, 16'h0FFF, 12'hFFF};

        #2 rst = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            check("reset_ctl", {SS_n, SCLK, MOSI, scan_done}, 4'b1100);
            check("reset_pots", {POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME}, 0);
        end
        rst = 1'b0;

        // First conversion: POT_LP takes 12'hABC exactly when SS_n rises
        ok = 0;
        pre_lp = POT_LP;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (fall_cnt == 2 && SS_n) begin ok = 1; break; end
            pre_lp = POT_LP;
        end
        check("wait_first_store", ok, 1);
        check("lp_before_rise", pre_lp, 12'h000);
        check("lp_at_rise", POT_LP, 12'hABC);
        check("others_at_rise", {POT_B1, POT_B2, POT_B3, POT_HP, VOLUME}, 0);

        // Two full scans
        ok = 0;
        for (int c = 0; c < 15000; c++) begin
            @(posedge clk); #1;
            if (done_cyc.size() >= 2) begin ok = 1; break; end
        end
        check("wait_two_scans", ok, 1);
        for (int i = 0; i < 6; i++) check($sformatf("pot%0d", i), pot_of(i), tbl[i].pot);
        check("cmd_log_len", cmd_log.size() >= 13, 1);
        if (cmd_log.size() >= 13) begin
            for (int k = 0; k < 6; k++) begin
                check($sformatf("frame1_cmd%0d", k), cmd_log[2*k], tbl[k].cmd);
                check($sformatf("frame2_cmd%0d", k), cmd_log[2*k+1], tbl[k].cmd);
            end
            check("frame1_wrap", cmd_log[12], 16'h0800);
        end
        if (done_cyc.size() >= 2) begin
            check("done_after_vol", done_cyc[0] - vol_cyc, 1);
            check("done_spacing", done_cyc[1] - done_cyc[0], 6720);
        end

        // Reset during FRAME2 of POT_B2 in the third scan
        ok = 0;
        for (int c = 0; c < 8000; c++) begin
            @(posedge clk); #1;
            if (fall_cnt == 30) begin ok = 1; break; end
        end
        check("wait_b2_frame2", ok, 1);
        repeat (199) @(posedge clk);
        #1;
        check("pre_reset_ss_low", SS_n, 1'b0);
        if (cmd_log.size() >= 29) check("pre_reset_b2_cmd", cmd_log[28], 16'h2000);
        rst = 1'b1;
        #1;
        check("abort_ctl", {SS_n, SCLK, MOSI}, 3'b110);
        check("abort_pots", {POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME}, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_hold_pots", {POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME}, 0);
        n = cmd_log.size();
        rst = 1'b0;
        ok = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (cmd_log.size() > n) begin ok = 1; break; end
        end
        check("wait_restart_frame", ok, 1);
        if (ok) check("restart_cmd", cmd_log[n], 16'h0800);

        check("ss_low_len", err_low, 0);
        check("ss_gap_len", err_gap, 0);
        check("sclk_rises", err_rises, 0);
        check("sclk_half_period", err_run, 0);
        check("mosi_stable", err_mosi, 0);
        check("idle_levels", err_idle, 0);
        check("frame1_data_leak", err_1234, 0);
        check("done_width", err_done_w, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
